cpu_seq_ctrl: RTL and testbench



---
 rtl/cpu_ctrl_pkg.sv | 52 +++++
 rtl/cpu_instr_decode.sv | 54 +++++
 rtl/cpu_seq_ctrl.sv | 218 +++++++++++++++++++++
 tb/tb_cpu_seq_ctrl.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared types and constants for the CPU control sequencer and its instruction decoder.
package cpu_ctrl_pkg;

    localparam int unsigned ILEN    = 16;
    localparam int unsigned OP_W    = 4;
    localparam int unsigned REG_W   = 4;
    localparam int unsigned OP_LSB  = 12;
    localparam int unsigned RD_LSB  = 8;
    localparam int unsigned RS1_LSB = 4;
    localparam int unsigned RS2_LSB = 0;

    typedef enum logic [3:0] {
        OP_ADD  = 4'h0,
        OP_SUB  = 4'h1,
        OP_AND  = 4'h2,
        OP_OR   = 4'h3,
        OP_XOR  = 4'h4,
        OP_ADDI = 4'h5,
        OP_JMP  = 4'h6,
        OP_BZ   = 4'h7,
        OP_HALT = 4'hF
    } opcode_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_WB,
        ST_HALT
    } state_e;

    typedef enum logic [2:0] {
        CLS_ALU,
        CLS_ADDI,
        CLS_JMP,
        CLS_BZ,
        CLS_HALT,
        CLS_NOP
    } op_class_e;

    localparam logic [1:0] RS2_SEL_REG  = 2'b00;
    localparam logic [1:0] RS2_SEL_IMM  = 2'b01;
    localparam logic [1:0] RS2_SEL_ZERO = 2'b10;

    // Extracts one 4-bit instruction field starting at bit lsb.
    function automatic logic [REG_W-1:0] get_field(input logic [ILEN-1:0] instr,
                                                   input int unsigned      lsb);
        return instr[lsb +: REG_W];
    endfunction

endpackage

// File: rtl/cpu_instr_decode.sv
// Combinational instruction decoder: splits an instruction into fields, class,
// rs2 operand select, zero-extended immediate and jump target.
module cpu_instr_decode
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned N  = 16,
    parameter int unsigned AW = 8
) (
    input  logic [ILEN-1:0]  i_instr,
    output logic [OP_W-1:0]  o_opcode_c,
    output logic [REG_W-1:0] o_rd_c,
    output logic [REG_W-1:0] o_rs1_c,
    output logic [REG_W-1:0] o_rs2_c,
    output op_class_e        o_cls_c,
    output logic [1:0]       o_rs2_sel_c,
    output logic [N-1:0]     o_imm_c,
    output logic             o_writes_c,
    output logic [AW-1:0]    o_target_c
);

    logic [OP_W-1:0] w_op;

    assign w_op        = get_field(i_instr, OP_LSB);
    assign o_opcode_c  = w_op;
    assign o_rd_c      = get_field(i_instr, RD_LSB);
    assign o_rs1_c     = get_field(i_instr, RS1_LSB);
    assign o_rs2_c     = get_field(i_instr, RS2_LSB);
    assign o_imm_c     = N'(get_field(i_instr, RS2_LSB));
    assign o_target_c  = i_instr[AW-1:0];

    // Unlisted opcodes fall through to NOP with a zero rs2 operand.
    always_comb begin
        o_cls_c     = CLS_NOP;
        o_rs2_sel_c = RS2_SEL_ZERO;
        o_writes_c  = 1'b0;
        case (w_op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                o_cls_c     = CLS_ALU;
                o_rs2_sel_c = RS2_SEL_REG;
                o_writes_c  = 1'b1;
            end
            OP_ADDI: begin
                o_cls_c     = CLS_ADDI;
                o_rs2_sel_c = RS2_SEL_IMM;
                o_writes_c  = 1'b1;
            end
            OP_JMP:  o_cls_c = CLS_JMP;
            OP_BZ:   o_cls_c = CLS_BZ;
            OP_HALT: o_cls_c = CLS_HALT;
            default: ;
        endcase
    end

endmodule

// File: rtl/cpu_seq_ctrl.sv
// Multi-cycle fetch/decode/exec/writeback sequencer for the 16-bit CPU datapath.
// Optional retired-instruction counter enabled by defining CPU_SEQ_PERF_CNT_EN.
module cpu_seq_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned N   = 16,
    parameter int unsigned AW  = 8,
    parameter int unsigned OPW = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             imem_req,
    output logic [AW-1:0]    imem_addr,
    input  logic             imem_ack,
    input  logic [ILEN-1:0]  imem_rdata,
    input  logic             alu_zero,
    output logic [OPW-1:0]   opcode,
    output logic [REG_W-1:0] rd_addr,
    output logic [REG_W-1:0] rs1_addr,
    output logic [REG_W-1:0] rs2_addr,
    output logic [1:0]       rs2_sel,
    output logic [N-1:0]     imm,
    output logic             alu_en,
    output logic             rf_we,
    output logic [AW-1:0]    pc,
    output logic             busy,
    output logic             halted
`ifdef CPU_SEQ_PERF_CNT_EN
    ,
    output logic [15:0]      instret_cnt
`endif
);

    state_e           r_state;
    state_e           w_state_nxt;
    logic [ILEN-1:0]  r_instr;
    logic [ILEN-1:0]  w_instr_nxt;
    logic [AW-1:0]    r_pc;
    logic [AW-1:0]    w_pc_nxt;
    logic             r_zero;
    logic             w_zero_nxt;
    logic             w_start_ok;
    logic             w_fields_on;

    logic [OP_W-1:0]  w_op;
    logic [REG_W-1:0] w_rd;
    logic [REG_W-1:0] w_rs1;
    logic [REG_W-1:0] w_rs2;
    op_class_e        w_cls;
    logic [1:0]       w_rs2_sel;
    logic [N-1:0]     w_imm;
    logic             w_writes;
    logic [AW-1:0]    w_target;

    logic             r_imem_req;
    logic             r_alu_en;
    logic             r_rf_we;
    logic             r_busy;
    logic             r_halted;
    logic [OPW-1:0]   r_opcode;
    logic [REG_W-1:0] r_rd;
    logic [REG_W-1:0] r_rs1;
    logic [REG_W-1:0] r_rs2;
    logic [1:0]       r_rs2_sel;
    logic [N-1:0]     r_imm;

    // Decode the word being latched this cycle so field outputs are ready in DECODE.
    assign w_instr_nxt = (r_state == ST_FETCH && imem_ack) ? imem_rdata : r_instr;
    assign w_start_ok  = start && (r_state == ST_IDLE || r_state == ST_HALT);

    cpu_instr_decode #(
        .N  (N),
        .AW (AW)
    ) u_decode (
        .i_instr     (w_instr_nxt),
        .o_opcode_c  (w_op),
        .o_rd_c      (w_rd),
        .o_rs1_c     (w_rs1),
        .o_rs2_c     (w_rs2),
        .o_cls_c     (w_cls),
        .o_rs2_sel_c (w_rs2_sel),
        .o_imm_c     (w_imm),
        .o_writes_c  (w_writes),
        .o_target_c  (w_target)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_zero_nxt  = r_zero;
        case (r_state)
            ST_IDLE: begin
                if (start) w_state_nxt = ST_FETCH;
            end
            ST_FETCH: begin
                if (imem_ack) w_state_nxt = ST_DECODE;
            end
            ST_DECODE: w_state_nxt = ST_EXEC;
            ST_EXEC: begin
                if (w_writes) w_zero_nxt = alu_zero;
                case (w_cls)
                    CLS_JMP: begin
                        w_pc_nxt    = w_target;
                        w_state_nxt = ST_FETCH;
                    end
                    CLS_BZ: begin
                        w_pc_nxt    = r_zero ? w_target : r_pc + AW'(1);
                        w_state_nxt = ST_FETCH;
                    end
                    CLS_HALT: w_state_nxt = ST_HALT;
                    default:  w_state_nxt = ST_WB;
                endcase
            end
            ST_WB: begin
                w_pc_nxt    = r_pc + AW'(1);
                w_state_nxt = ST_FETCH;
            end
            ST_HALT: begin
                if (start) begin
                    w_pc_nxt    = '0;
                    w_state_nxt = ST_FETCH;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_fields_on = (w_state_nxt == ST_DECODE) || (w_state_nxt == ST_EXEC) ||
                         (w_state_nxt == ST_WB);

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_instr    <= '0;
            r_pc       <= '0;
            r_zero     <= 1'b0;
            r_imem_req <= 1'b0;
            r_alu_en   <= 1'b0;
            r_rf_we    <= 1'b0;
            r_busy     <= 1'b0;
            r_halted   <= 1'b0;
            r_opcode   <= '0;
            r_rd       <= '0;
            r_rs1      <= '0;
            r_rs2      <= '0;
            r_rs2_sel  <= '0;
            r_imm      <= '0;
        end else begin
            r_instr    <= w_instr_nxt;
            r_pc       <= w_pc_nxt;
            r_zero     <= w_zero_nxt;
            r_imem_req <= (w_state_nxt == ST_FETCH);
            r_alu_en   <= (w_state_nxt == ST_EXEC) && w_writes;
            r_rf_we    <= (w_state_nxt == ST_WB) && w_writes;
            r_busy     <= !((w_state_nxt == ST_IDLE) || (w_state_nxt == ST_HALT));
            r_halted   <= (w_state_nxt == ST_HALT);
            if (w_fields_on) begin
                r_opcode  <= OPW'(w_op);
                r_rd      <= w_rd;
                r_rs1     <= w_rs1;
                r_rs2     <= w_rs2;
                r_rs2_sel <= w_rs2_sel;
                r_imm     <= w_imm;
            end else begin
                r_opcode  <= '0;
                r_rd      <= '0;
                r_rs1     <= '0;
                r_rs2     <= '0;
                r_rs2_sel <= '0;
                r_imm     <= '0;
            end
        end
    end

    assign imem_req  = r_imem_req;
    assign imem_addr = r_pc;
    assign pc        = r_pc;
    assign alu_en    = r_alu_en;
    assign rf_we     = r_rf_we;
    assign busy      = r_busy;
    assign halted    = r_halted;
    assign opcode    = r_opcode;
    assign rd_addr   = r_rd;
    assign rs1_addr  = r_rs1;
    assign rs2_addr  = r_rs2;
    assign rs2_sel   = r_rs2_sel;
    assign imm       = r_imm;

`ifdef CPU_SEQ_PERF_CNT_EN
    logic [15:0] r_instret;

    // Every instruction leaving EXEC retires, HALT included; saturates at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_instret <= '0;
        end else if (w_start_ok) begin
            r_instret <= '0;
        end else if (r_state == ST_EXEC && r_instret != 16'hFFFF) begin
            r_instret <= r_instret + 16'd1;
        end
    end

    assign instret_cnt = r_instret;
`else
    logic w_unused_start_ok;
    assign w_unused_start_ok = w_start_ok;
`endif

endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// Directed self-checking bench for cpu_seq_ctrl with a combinational instruction memory.
module tb_cpu_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic        alu_zero = 1'b0;
    logic [3:0]  opcode;
    logic [3:0]  rd_addr, rs1_addr, rs2_addr;
    logic [1:0]  rs2_sel;
    logic [15:0] imm;
    logic        alu_en, rf_we;
    logic [7:0]  pc;
    logic        busy, halted;
`ifdef CPU_SEQ_PERF_CNT_EN
    logic [15:0] instret_cnt;
`endif

    logic [15:0] mem [256];
    logic        ack_on = 1'b1;
    int          n_checks = 0;
    int          n_errors = 0;

    assign imem_ack   = ack_on;
    assign imem_rdata = mem[imem_addr];

    always #5 clk = ~clk;

    cpu_seq_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .alu_zero   (alu_zero),
        .opcode     (opcode),
        .rd_addr    (rd_addr),
        .rs1_addr   (rs1_addr),
        .rs2_addr   (rs2_addr),
        .rs2_sel    (rs2_sel),
        .imm        (imm),
        .alu_en     (alu_en),
        .rf_we      (rf_we),
        .pc         (pc),
        .busy       (busy),
        .halted     (halted)
`ifdef CPU_SEQ_PERF_CNT_EN
        ,
        .instret_cnt(instret_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'hE000;
        mem[8'h00] = 16'h0123;
        mem[8'h01] = 16'h7040;
        mem[8'h40] = 16'h5127;
        mem[8'h41] = 16'h7040;
        mem[8'h42] = 16'h60FF;
        mem[8'h10] = 16'hF000;

        tick();
        tick();
        chk("rst_req",    32'(imem_req), 32'd0);
        chk("rst_pc",     32'(pc),       32'd0);
        chk("rst_busy",   32'(busy),     32'd0);
        chk("rst_halted", 32'(halted),   32'd0);
        chk("rst_alu_en", 32'(alu_en),   32'd0);
        rst = 1'b0;
        tick();
        chk("idle_busy",  32'(busy),     32'd0);

        // ADD r1,r2,r3 at pc 0 with zero-wait ack
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("add_c1_req",  32'(imem_req),  32'd1);
        chk("add_c1_addr", 32'(imem_addr), 32'd0);
        chk("add_c1_busy", 32'(busy),      32'd1);
        tick();
        chk("add_c2_op",   32'(opcode),    32'd0);
        chk("add_c2_rd",   32'(rd_addr),   32'd1);
        chk("add_c2_rs1",  32'(rs1_addr),  32'd2);
        chk("add_c2_rs2",  32'(rs2_addr),  32'd3);
        chk("add_c2_sel",  32'(rs2_sel),   32'd0);
        chk("add_c2_alu",  32'(alu_en),    32'd0);
        chk("add_c2_req",  32'(imem_req),  32'd0);
        alu_zero = 1'b1;
        tick();
        chk("add_c3_alu",  32'(alu_en),    32'd1);
        chk("add_c3_we",   32'(rf_we),     32'd0);
        tick();
        alu_zero = 1'b0;
        chk("add_c4_we",   32'(rf_we),     32'd1);
        chk("add_c4_alu",  32'(alu_en),    32'd0);
        chk("add_c4_op",   32'(opcode),    32'd0);
        tick();
        chk("add_pc",      32'(pc),        32'd1);
        chk("add_nxt_req", 32'(imem_req),  32'd1);
        chk("add_nxt_we",  32'(rf_we),     32'd0);

        // BZ 0x40 with zero flag set: taken
        tick();
        chk("bz1_op",  32'(opcode),  32'd7);
        chk("bz1_sel", 32'(rs2_sel), 32'd2);
        tick();
        chk("bz1_alu", 32'(alu_en),  32'd0);
        chk("bz1_we",  32'(rf_we),   32'd0);
        tick();
        chk("bz1_pc",  32'(pc),      32'h40);
        chk("bz1_req", 32'(imem_req), 32'd1);
        chk("bz1_we2", 32'(rf_we),   32'd0);

        // ADDI with ack delayed 3 cycles
        ack_on = 1'b0;
        chk("addi_w1_req", 32'(imem_req), 32'd1);
        tick();
        chk("addi_w2_req", 32'(imem_req), 32'd1);
        chk("addi_w2_adr", 32'(imem_addr), 32'h40);
        tick();
        chk("addi_w3_req", 32'(imem_req), 32'd1);
        tick();
        chk("addi_w4_req", 32'(imem_req), 32'd1);
        chk("addi_w4_adr", 32'(imem_addr), 32'h40);
        ack_on = 1'b1;
        tick();
        chk("addi_op",  32'(opcode),   32'd5);
        chk("addi_sel", 32'(rs2_sel),  32'd1);
        chk("addi_imm", 32'(imm),      32'h0007);
        chk("addi_rd",  32'(rd_addr),  32'd1);
        chk("addi_req", 32'(imem_req), 32'd0);
        tick();
        chk("addi_alu", 32'(alu_en),   32'd1);
        tick();
        chk("addi_we",  32'(rf_we),    32'd1);
        chk("addi_imm2", 32'(imm),     32'h0007);
        tick();
        chk("addi_pc",  32'(pc),       32'h41);

        // BZ with zero flag cleared by ADDI: not taken
        tick();
        tick();
        tick();
        chk("bz0_pc", 32'(pc), 32'h42);

        // JMP 0xFF; start pulse while busy must be ignored
        tick();
        start = 1'b1;
        chk("jmp_op", 32'(opcode), 32'd6);
        tick();
        start = 1'b0;
        tick();
        chk("jmp_pc",   32'(pc),       32'hFF);
        chk("jmp_busy", 32'(busy),     32'd1);

        // NOP at 0xFF then pc wraps to 0; redirect 0 to JMP 0x10
        mem[8'h00] = 16'h6010;
        tick();
        chk("nop_op",  32'(opcode),  32'hE);
        chk("nop_sel", 32'(rs2_sel), 32'd2);
        tick();
        chk("nop_alu", 32'(alu_en),  32'd0);
        tick();
        chk("nop_we",   32'(rf_we),  32'd0);
        chk("nop_busy", 32'(busy),   32'd1);
        tick();
        chk("wrap_pc", 32'(pc), 32'd0);

        // JMP 0x10 then HALT
        tick();
        tick();
        tick();
        chk("j10_pc", 32'(pc), 32'h10);
        tick();
        chk("halt_op", 32'(opcode), 32'hF);
        tick();
        tick();
        chk("halt_halted", 32'(halted),   32'd1);
        chk("halt_busy",   32'(busy),     32'd0);
        chk("halt_pc",     32'(pc),       32'h10);
        chk("halt_req",    32'(imem_req), 32'd0);
        chk("halt_op0",    32'(opcode),   32'd0);
`ifdef CPU_SEQ_PERF_CNT_EN
        chk("instret_8",   32'(instret_cnt), 32'd8);
`endif
        tick();
        tick();
        chk("halt_hold",   32'(halted),   32'd1);
        chk("halt_pc2",    32'(pc),       32'h10);

        // Restart from HALT
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("rs_pc",     32'(pc),       32'd0);
        chk("rs_req",    32'(imem_req), 32'd1);
        chk("rs_halted", 32'(halted),   32'd0);
        chk("rs_busy",   32'(busy),     32'd1);
`ifdef CPU_SEQ_PERF_CNT_EN
        chk("instret_clr", 32'(instret_cnt), 32'd0);
`endif
        tick();
        tick();
        tick();
        chk("rs_j10_pc", 32'(pc), 32'h10);

        // Reset with a fetch pending, then a late ack
        ack_on = 1'b0;
        tick();
        chk("pend_req",  32'(imem_req),  32'd1);
        chk("pend_addr", 32'(imem_addr), 32'h10);
        rst = 1'b1;
        #1;
        chk("arst_req",  32'(imem_req), 32'd0);
        chk("arst_pc",   32'(pc),       32'd0);
        chk("arst_busy", 32'(busy),     32'd0);
        ack_on = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        tick();
        chk("late_req",  32'(imem_req), 32'd0);
        chk("late_busy", 32'(busy),     32'd0);
        chk("late_pc",   32'(pc),       32'd0);
        chk("late_op",   32'(opcode),   32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
